// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with branch-compare flags, plus an iterative
// radix-2 multiply/divide unit that holds decode off until its result is ready.
module ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CSR_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           instr_rdata_i,
    input  logic [31:0]           pc_ex_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic                  src_a_pc_i,
    input  logic                  src_b_imm_i,
    input  logic [4:0]            alu_op_i,
    input  logic                  stall_i,
    output logic                  valid_o,
    output logic [31:0]           instr_rdata_o,
    output logic [31:0]           pc_mem_o,
    output logic [DATA_WIDTH-1:0] data_a_o,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [CSR_WIDTH-1:0]  alu_csr_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam int SW = $clog2(W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_reg;
    logic [CW-1:0] count_reg;
    logic [2:0]    op_reg;
    logic [2*W-1:0] acc_reg;     // mul: {product_hi, multiplier}; div: {remainder, quotient}
    logic [W-1:0]  mcand_reg;    // mul: |multiplicand|; div: |divisor|
    logic          neg_hi_reg;
    logic          neg_rem_reg;
    logic          div_zero_reg;
    logic [W-1:0]  dividend_reg;

    logic          valid_reg;
    logic [31:0]   instr_reg;
    logic [31:0]   pc_reg;
    logic [W-1:0]  data_a_reg;
    logic [W-1:0]  data_b_reg;
    logic [W-1:0]  result_reg;
    logic [CSR_WIDTH-1:0] csr_reg;

    logic [W-1:0]  op_a, op_b;
    logic [SW-1:0] shamt;
    logic [W-1:0]  alu_res;
    logic          is_md;
    logic          fire;

    assign op_a  = src_a_pc_i  ? pc_ex_i : data_a_i;
    assign op_b  = src_b_imm_i ? imm_i   : data_b_i;
    assign shamt = op_b[SW-1:0];
    assign is_md = (alu_op_i[4:3] == 2'b10);

    always_comb begin
        alu_res = op_a + op_b;
        case (alu_op_i)
            5'd1:    alu_res = op_a - op_b;
            5'd2:    alu_res = op_a << shamt;
            5'd3:    alu_res = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            5'd4:    alu_res = {{(W-1){1'b0}}, op_a < op_b};
            5'd5:    alu_res = op_a ^ op_b;
            5'd6:    alu_res = op_a >> shamt;
            5'd7:    alu_res = $signed(op_a) >>> shamt;
            5'd8:    alu_res = op_a | op_b;
            5'd9:    alu_res = op_a & op_b;
            5'd10:   alu_res = op_b;
            default: alu_res = op_a + op_b;
        endcase
    end

    // Operand signedness per op: low bits of MUL are sign-agnostic, so it is
    // treated as signed x signed like MULH.
    logic         start_div, a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] abs_a, abs_b;

    assign start_div = alu_op_i[2];
    assign a_signed  = start_div ? !alu_op_i[0] : (alu_op_i[1:0] != 2'b11);
    assign b_signed  = start_div ? !alu_op_i[0] : !alu_op_i[1];
    assign a_neg     = a_signed && op_a[W-1];
    assign b_neg     = b_signed && op_b[W-1];
    assign abs_a     = a_neg ? (~op_a + 1'b1) : op_a;
    assign abs_b     = b_neg ? (~op_b + 1'b1) : op_b;

    // One iteration of shift-add multiply or restoring divide.
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [2*W-1:0] step_next;

    assign mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}});
    assign div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_reg};

    always_comb begin
        if (op_reg[2]) begin
            step_next = div_ge ? {div_shift[W-1:0] - mcand_reg, acc_reg[W-2:0], 1'b1}
                               : {div_shift[W-1:0], acc_reg[W-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, acc_reg[W-1:1]};
        end
    end

    logic [2*W-1:0] prod_signed;
    logic [W-1:0]   quo_signed, rem_signed, md_result, final_result;

    assign prod_signed = neg_hi_reg  ? (~acc_reg + 1'b1) : acc_reg;
    assign quo_signed  = neg_hi_reg  ? (~acc_reg[W-1:0] + 1'b1) : acc_reg[W-1:0];
    assign rem_signed  = neg_rem_reg ? (~acc_reg[2*W-1:W] + 1'b1) : acc_reg[2*W-1:W];

    always_comb begin
        if (!op_reg[2])
            md_result = (op_reg[1:0] == 2'b00) ? prod_signed[W-1:0] : prod_signed[2*W-1:W];
        else if (op_reg[1])
            md_result = div_zero_reg ? dividend_reg : rem_signed;
        else
            md_result = div_zero_reg ? {W{1'b1}} : quo_signed;
    end

    assign final_result = (state_reg == ST_DONE) ? md_result : alu_res;

    assign ready_o = !stall_i && (((state_reg == ST_IDLE) && !(valid_i && is_md))
                                  || (state_reg == ST_DONE));
    assign fire    = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            op_reg       <= '0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            neg_hi_reg   <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            dividend_reg <= '0;
        end else if (flush_i) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (valid_i && is_md) begin
                        state_reg    <= ST_BUSY;
                        count_reg    <= '0;
                        op_reg       <= alu_op_i[2:0];
                        acc_reg      <= start_div ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
                        mcand_reg    <= start_div ? abs_b : abs_a;
                        neg_hi_reg   <= a_neg ^ b_neg;
                        neg_rem_reg  <= a_neg;
                        div_zero_reg <= (op_b == '0);
                        dividend_reg <= op_a;
                    end
                end
                ST_BUSY: begin
                    acc_reg   <= step_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(W-1))
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (!stall_i)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg  <= 1'b0;
            instr_reg  <= '0;
            pc_reg     <= '0;
            data_a_reg <= '0;
            data_b_reg <= '0;
            result_reg <= '0;
            csr_reg    <= '0;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (!stall_i) begin
            valid_reg <= fire;
            if (fire) begin
                instr_reg  <= instr_rdata_i;
                pc_reg     <= pc_ex_i;
                data_a_reg <= data_a_i;
                data_b_reg <= data_b_i;
                result_reg <= final_result;
                csr_reg    <= {final_result == '0, data_a_i < data_b_i,
                               $signed(data_a_i) < $signed(data_b_i), data_a_i == data_b_i};
            end
        end
    end

    assign valid_o       = valid_reg;
    assign instr_rdata_o = instr_reg;
    assign pc_mem_o      = pc_reg;
    assign data_a_o      = data_a_reg;
    assign data_b_o      = data_b_reg;
    assign alu_result_o  = result_reg;
    assign alu_csr_o     = csr_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, compare flags, mul/div latency and
// special cases, stall in BUSY/DONE, flush and mid-operation reset.
module tb_ex_stage;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic        ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] imm;
    logic        src_a_pc;
    logic        src_b_imm;
    logic [4:0]  alu_op;
    logic        stall;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] data_a_out;
    logic [31:0] data_b_out;
    logic [31:0] result;
    logic [3:0]  csr;

    int tests_run  = 0;
    int fail_count = 0;
    logic [31:0] exp_prev;

    ex_stage #(.DATA_WIDTH(32), .CSR_WIDTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .valid_i       (valid_in),
        .ready_o       (ready),
        .instr_rdata_i (instr_in),
        .pc_ex_i       (pc_in),
        .data_a_i      (data_a),
        .data_b_i      (data_b),
        .imm_i         (imm),
        .src_a_pc_i    (src_a_pc),
        .src_b_imm_i   (src_b_imm),
        .alu_op_i      (alu_op),
        .stall_i       (stall),
        .valid_o       (valid_out),
        .instr_rdata_o (instr_out),
        .pc_mem_o      (pc_out),
        .data_a_o      (data_a_out),
        .data_b_o      (data_b_out),
        .alu_result_o  (result),
        .alu_csr_o     (csr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        data_a    = a;
        data_b    = b;
        src_a_pc  = 1'b0;
        src_b_imm = 1'b0;
        alu_op    = op;
        valid_in  = 1'b1;
    endtask

    // Present a mul/div op, count ready-low cycles, then check the result.
    task automatic run_md(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [31:0] exp, input logic [3:0] exp_csr);
        int lows;
        set_op(a, b, op);
        #1;
        lows = 0;
        while (ready !== 1'b1 && lows < 100) begin
            tick();
            lows++;
        end
        check({tag, "_lowcycles"}, 32'(lows), 32'd33);
        tick();
        check({tag, "_result"}, result, exp);
        check({tag, "_csr"}, 32'(csr), 32'(exp_csr));
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        $display("[TB] %s a=%h b=%h op=%0d -> %h", tag, a, b, op, result);
        valid_in = 1'b0;
        exp_prev = exp;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; stall = 1'b0;
        instr_in = 32'h0; pc_in = 32'h0; data_a = 32'h0; data_b = 32'h0; imm = 32'h0;
        src_a_pc = 1'b0; src_b_imm = 1'b0; alu_op = 5'd0;
        tick(); tick();
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_csr", 32'(csr), 32'h0);
        check("reset_ready", 32'(ready), 32'd1);
        $display("[TB] reset done");
        rst = 1'b0;

        // ADD with immediate
        set_op(32'd5, 32'd0, 5'd0);
        imm = 32'hFFFF_FFF9; src_b_imm = 1'b1; instr_in = 32'h0000_0013; pc_in = 32'h0000_0100;
        tick();
        check("add_result", result, 32'hFFFF_FFFE);
        check("add_valid", 32'(valid_out), 32'd1);
        check("add_csr", 32'(csr), 32'h0);
        check("add_instr", instr_out, 32'h0000_0013);
        check("add_pc", pc_out, 32'h0000_0100);
        check("add_data_a", data_a_out, 32'd5);
        $display("[TB] ADD -> %h", result);

        // SRA then SLTU back-to-back
        set_op(32'h8000_0000, 32'd0, 5'd7);
        imm = 32'd4; src_b_imm = 1'b1; pc_in = 32'h0000_0104;
        tick();
        check("sra_result", result, 32'hF800_0000);
        check("sra_csr", 32'(csr), 32'h2);
        $display("[TB] SRA -> %h", result);
        set_op(32'd1, 32'hFFFF_FFFF, 5'd4);
        pc_in = 32'h0000_0108;
        tick();
        check("sltu_result", result, 32'd1);
        check("sltu_csr", 32'(csr), 32'h4);
        check("sltu_valid", 32'(valid_out), 32'd1);
        check("sltu_data_b", data_b_out, 32'hFFFF_FFFF);
        $display("[TB] SLTU -> %h", result);

        // SUB to zero sets eq and zero flags
        set_op(32'd9, 32'd9, 5'd1);
        tick();
        check("sub_result", result, 32'h0);
        check("sub_csr", 32'(csr), 32'h9);
        $display("[TB] SUB -> %h", result);

        // AUIPC-style: PC + imm, rs1 still forwarded
        set_op(32'h55, 32'h55, 5'd0);
        src_a_pc = 1'b1; src_b_imm = 1'b1; pc_in = 32'h0000_1000; imm = 32'h0000_2000;
        tick();
        check("auipc_result", result, 32'h0000_3000);
        check("auipc_data_a", data_a_out, 32'h55);
        check("auipc_csr", 32'(csr), 32'h1);
        $display("[TB] AUIPC -> %h", result);

        // bubble
        valid_in = 1'b0;
        tick();
        check("bubble_valid", 32'(valid_out), 32'd0);
        $display("[TB] bubble valid_o=%0d", valid_out);

        run_md("mulh",   32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000, 4'h1);
        run_md("div0",   32'd7,         32'd0,         5'd20, 32'hFFFF_FFFF, 4'h0);
        run_md("rem_ovf",32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0,         4'hE);
        run_md("divu",   32'd100,       32'd7,         5'd21, 32'd14,        4'h0);
        run_md("mul",    32'hFFFF_FFFD, 32'd5,         5'd16, 32'hFFFF_FFF1, 4'h2);
        run_md("div_neg",32'hFFFF_FFF9, 32'd2,         5'd20, 32'hFFFF_FFFD, 4'h2);
        run_md("rem_neg",32'hFFFF_FFF9, 32'd2,         5'd22, 32'hFFFF_FFFF, 4'h2);
        run_md("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFF, 4'h1);
        run_md("remu0",  32'd7,         32'd0,         5'd23, 32'd7,         4'h0);

        // stall raised during BUSY (must not pause) and held 5 cycles into DONE
        set_op(32'd100, 32'd7, 5'd21);
        for (int i = 0; i < 10; i++) tick();
        stall = 1'b1;
        #1;
        check("stall_busy_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 23; i++) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_done_valid", 32'(valid_out), 32'd0);
            check("stall_done_result", result, exp_prev);
            check("stall_done_ready", 32'(ready), 32'd0);
        end
        stall = 1'b0;
        #1;
        check("stall_release_ready", 32'(ready), 32'd1);
        tick();
        check("stall_result", result, 32'd14);
        check("stall_valid", 32'(valid_out), 32'd1);
        $display("[TB] stalled DIVU -> %h", result);
        valid_in = 1'b0;

        // flush overrides stall and clears valid_o
        set_op(32'd1, 32'd2, 5'd0);
        tick();
        check("pre_flush_result", result, 32'd3);
        set_op(32'd10, 32'd20, 5'd0);
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
        check("flush_valid", 32'(valid_out), 32'd0);
        $display("[TB] flush single-cycle valid_o=%0d", valid_out);

        // flush at BUSY count 10
        set_op(32'd3, 32'd5, 5'd16);
        for (int i = 0; i < 11; i++) tick();
        check("flush_busy_ready", 32'(ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; valid_in = 1'b0;
        #1;
        check("flush_idle_ready", 32'(ready), 32'd1);
        check("flush_busy_valid", 32'(valid_out), 32'd0);
        $display("[TB] flush during BUSY, ready_o=%0d", ready);
        run_md("mul_restart", 32'd3, 32'd5, 5'd16, 32'd15, 4'h6);

        // reset mid-BUSY
        set_op(32'd4, 32'd6, 5'd0);
        instr_in = 32'hDEAD_BEEF; pc_in = 32'h0000_0200;
        tick();
        check("pre_rst_result", result, 32'd10);
        set_op(32'd50, 32'd3, 5'd20);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        valid_in = 1'b0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_data_a", data_a_out, 32'h0);
        check("rst_data_b", data_b_out, 32'h0);
        check("rst_csr", 32'(csr), 32'h0);
        check("rst_ready", 32'(ready), 32'd1);
        $display("[TB] reset mid-BUSY, outputs cleared");
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
